// File: rtl/noc_position_mux_pipe_if.sv
// ============================================================================
//  Module      : noc_position_mux_pipe_if
//  Description : Link/router handshake bundle for noc_position_mux_pipe.
//                One valid/flit/ready triple per direction for each of:
//                  lnk_in  : ingress from neighbour links   (toward the mux)
//                  rtr_out : ingress toward router inputs   (from the mux)
//                  rtr_in  : egress from router outputs     (toward the mux)
//                  lnk_out : egress to neighbour links      (from the mux)
//                Modport slave is the mux view, master the environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_position_mux_pipe_if #(
    parameter int NUM_PORTS  = 4,
    parameter int FLIT_WIDTH = 64
);
    logic [NUM_PORTS-1:0]                 lnk_in_valid;
    logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0] lnk_in_flit;
    logic [NUM_PORTS-1:0]                 lnk_in_ready;

    logic [NUM_PORTS-1:0]                 rtr_out_valid;
    logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0] rtr_out_flit;
    logic [NUM_PORTS-1:0]                 rtr_out_ready;

    logic [NUM_PORTS-1:0]                 rtr_in_valid;
    logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0] rtr_in_flit;
    logic [NUM_PORTS-1:0]                 rtr_in_ready;

    logic [NUM_PORTS-1:0]                 lnk_out_valid;
    logic [NUM_PORTS-1:0][FLIT_WIDTH-1:0] lnk_out_flit;
    logic [NUM_PORTS-1:0]                 lnk_out_ready;

    modport slave (
        input  lnk_in_valid, lnk_in_flit,
        output lnk_in_ready,
        output rtr_out_valid, rtr_out_flit,
        input  rtr_out_ready,
        input  rtr_in_valid, rtr_in_flit,
        output rtr_in_ready,
        output lnk_out_valid, lnk_out_flit,
        input  lnk_out_ready
    );

    modport master (
        output lnk_in_valid, lnk_in_flit,
        input  lnk_in_ready,
        input  rtr_out_valid, rtr_out_flit,
        output rtr_out_ready,
        output rtr_in_valid, rtr_in_flit,
        input  rtr_in_ready,
        input  lnk_out_valid, lnk_out_flit,
        output lnk_out_ready
    );
endinterface

`default_nettype wire

// File: rtl/noc_position_mux_pipe.sv
// ============================================================================
//  Module      : noc_position_mux_pipe
//  Description : Per-direction pipeline stage between mesh links and a router.
//                Each enabled direction p gets an ingress skid buffer
//                (lnk_in[p] -> rtr_out[p]) and an egress skid buffer
//                (rtr_in[p] -> lnk_out[p]). Directions marked 0 in PORT_EN
//                (mesh edges) hold no storage: they never accept link flits,
//                never present valid, and silently sink router flits.
//  Ports       : noc_clk  - single rising-edge clock
//                noc_rst  - synchronous active-high reset
//                bus      - noc_position_mux_pipe_if.slave handshake bundle
//                cnt_clr, ingress_cnt, egress_cnt
//                         - only with NOC_POS_MUX_STATS_EN defined: per-buffer
//                           saturating counts of output-side handshakes
//  Options     : `define NOC_POS_MUX_STATS_EN to add the statistics counters;
//                the datapath is identical either way.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// Two-entry skid buffer. Ready is a flop (next state != FULL), so there is no
// combinational path from i_ready to o_ready; valid comes from state only.
// ----------------------------------------------------------------------------
module noc_position_mux_pipe_skid #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ready;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [WIDTH-1:0] r_mem [2];
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_state != ST_EMPTY);
    assign o_ready = r_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_valid & r_ready;
    assign w_pop   = o_valid & i_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
            end
            // A push cannot coincide with FULL because ready is low there.
            ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_ready  <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt != ST_FULL);
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Payload storage carries no reset; occupancy state alone decides what is
    // visible, so stale entries can never be presented after reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module noc_position_mux_pipe #(
    parameter int                 NUM_PORTS  = 4,
    parameter int                 FLIT_WIDTH = 64,
    parameter logic [NUM_PORTS-1:0] PORT_EN  = {NUM_PORTS{1'b1}}
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst,
`ifdef NOC_POS_MUX_STATS_EN
    input  logic                        cnt_clr,
    output logic [NUM_PORTS-1:0][31:0]  ingress_cnt,
    output logic [NUM_PORTS-1:0][31:0]  egress_cnt,
`endif
    noc_position_mux_pipe_if.slave      bus
);
    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    // Output-side handshakes per buffer; they feed the optional counters.
    logic [NUM_PORTS-1:0] w_ing_fire;
    logic [NUM_PORTS-1:0] w_egr_fire;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        if (PORT_EN[p]) begin : g_en
            logic                  w_ing_ready;
            logic                  w_ing_valid;
            logic [FLIT_WIDTH-1:0] w_ing_flit;
            logic                  w_egr_ready;
            logic                  w_egr_valid;
            logic [FLIT_WIDTH-1:0] w_egr_flit;

            noc_position_mux_pipe_skid #(.WIDTH(FLIT_WIDTH)) u_ingress (
                .clk     (noc_clk),
                .rst     (noc_rst),
                .i_valid (bus.lnk_in_valid[p]),
                .i_data  (bus.lnk_in_flit[p]),
                .o_ready (w_ing_ready),
                .o_valid (w_ing_valid),
                .o_data  (w_ing_flit),
                .i_ready (bus.rtr_out_ready[p])
            );

            noc_position_mux_pipe_skid #(.WIDTH(FLIT_WIDTH)) u_egress (
                .clk     (noc_clk),
                .rst     (noc_rst),
                .i_valid (bus.rtr_in_valid[p]),
                .i_data  (bus.rtr_in_flit[p]),
                .o_ready (w_egr_ready),
                .o_valid (w_egr_valid),
                .o_data  (w_egr_flit),
                .i_ready (bus.lnk_out_ready[p])
            );

            assign bus.lnk_in_ready[p]  = w_ing_ready;
            assign bus.rtr_out_valid[p] = w_ing_valid;
            assign bus.rtr_out_flit[p]  = w_ing_flit;
            assign bus.rtr_in_ready[p]  = w_egr_ready;
            assign bus.lnk_out_valid[p] = w_egr_valid;
            assign bus.lnk_out_flit[p]  = w_egr_flit;
            assign w_ing_fire[p]        = w_ing_valid & bus.rtr_out_ready[p];
            assign w_egr_fire[p]        = w_egr_valid & bus.lnk_out_ready[p];
        end else begin : g_dis
            // Mesh edge: link side is closed, router flits are accepted and
            // dropped so a misrouted flit cannot wedge the router output.
            assign bus.lnk_in_ready[p]  = 1'b0;
            assign bus.rtr_out_valid[p] = 1'b0;
            assign bus.rtr_out_flit[p]  = '0;
            assign bus.rtr_in_ready[p]  = 1'b1;
            assign bus.lnk_out_valid[p] = 1'b0;
            assign bus.lnk_out_flit[p]  = '0;
            assign w_ing_fire[p]        = 1'b0;
            assign w_egr_fire[p]        = 1'b0;

            logic w_unused_edge;
            assign w_unused_edge = ^{bus.lnk_in_valid[p], bus.lnk_in_flit[p],
                                     bus.rtr_out_ready[p], bus.rtr_in_valid[p],
                                     bus.rtr_in_flit[p], bus.lnk_out_ready[p]};
        end
    end

`ifdef NOC_POS_MUX_STATS_EN
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
        logic [31:0] r_ing_cnt;
        logic [31:0] r_egr_cnt;

        // Clear wins over a same-cycle increment; counts saturate at all-ones.
        always_ff @(posedge noc_clk) begin
            if (noc_rst || cnt_clr) begin
                r_ing_cnt <= '0;
                r_egr_cnt <= '0;
            end else begin
                if (w_ing_fire[p] && (r_ing_cnt != c_cnt_max))
                    r_ing_cnt <= r_ing_cnt + 32'd1;
                if (w_egr_fire[p] && (r_egr_cnt != c_cnt_max))
                    r_egr_cnt <= r_egr_cnt + 32'd1;
            end
        end

        assign ingress_cnt[p] = r_ing_cnt;
        assign egress_cnt[p]  = r_egr_cnt;
    end
`else
    logic w_unused_fire;
    assign w_unused_fire = ^{w_ing_fire, w_egr_fire, c_cnt_max};
`endif
endmodule

`default_nettype wire

// File: tb/tb_noc_position_mux_pipe.sv
// ============================================================================
//  Module      : tb_noc_position_mux_pipe
//  Description : Self-checking bench for noc_position_mux_pipe. A queue per
//                buffer models the two-entry FIFO behaviour; a second
//                instance with the east direction disabled checks edge
//                behaviour. Statistics checks compile in with
//                NOC_POS_MUX_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_position_mux_pipe;
    localparam int NP     = 4;
    localparam int FW     = 64;
    localparam int NB     = 8;     // 0..3 ingress, 4..7 egress
    localparam int NFLITS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clr = 1'b0;
    always #5 clk = ~clk;

    noc_position_mux_pipe_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus ();
    noc_position_mux_pipe_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus_e ();

`ifdef NOC_POS_MUX_STATS_EN
    logic [NP-1:0][31:0] ing_cnt, egr_cnt, ing_cnt_e, egr_cnt_e;
`endif

    noc_position_mux_pipe #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .PORT_EN(4'b1111)) u_dut (
        .noc_clk     (clk),
        .noc_rst     (rst),
`ifdef NOC_POS_MUX_STATS_EN
        .cnt_clr     (cnt_clr),
        .ingress_cnt (ing_cnt),
        .egress_cnt  (egr_cnt),
`endif
        .bus         (bus)
    );

    noc_position_mux_pipe #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .PORT_EN(4'b1110)) u_dut_edge (
        .noc_clk     (clk),
        .noc_rst     (rst),
`ifdef NOC_POS_MUX_STATS_EN
        .cnt_clr     (cnt_clr),
        .ingress_cnt (ing_cnt_e),
        .egress_cnt  (egr_cnt_e),
`endif
        .bus         (bus_e)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive state and reference model
    logic        in_v  [NB];
    logic [63:0] in_d  [NB];
    logic        out_r [NB];
    logic [63:0] q     [NB][$];
    logic [31:0] cnt_m [NB];
    int          sent  [NB];
    int          rcvd  [NB];
    bit          rdy_ok;
    bit          rec2;
    logic [63:0] obs2  [$];

    logic        f_in   [NB];
    logic        f_out  [NB];
    logic [63:0] f_in_d [NB];
    logic [63:0] f_out_d[NB];

    function automatic logic o_valid(int b);
        return (b < 4) ? bus.rtr_out_valid[b] : bus.lnk_out_valid[b-4];
    endfunction
    function automatic logic [63:0] o_flit(int b);
        return (b < 4) ? bus.rtr_out_flit[b] : bus.lnk_out_flit[b-4];
    endfunction
    function automatic logic i_ready(int b);
        return (b < 4) ? bus.lnk_in_ready[b] : bus.rtr_in_ready[b-4];
    endfunction

    task automatic apply();
        for (int b = 0; b < NB; b++) begin
            if (b < 4) begin
                bus.lnk_in_valid[b]  = in_v[b];
                bus.lnk_in_flit[b]   = in_d[b];
                bus.rtr_out_ready[b] = out_r[b];
            end else begin
                bus.rtr_in_valid[b-4]  = in_v[b];
                bus.rtr_in_flit[b-4]   = in_d[b];
                bus.lnk_out_ready[b-4] = out_r[b];
            end
        end
        bus_e.lnk_in_valid  = NP'($urandom);
        bus_e.rtr_in_valid  = NP'($urandom);
        bus_e.rtr_out_ready = NP'($urandom);
        bus_e.lnk_out_ready = NP'($urandom);
        for (int p = 0; p < NP; p++) begin
            bus_e.lnk_in_flit[p] = {$urandom, $urandom};
            bus_e.rtr_in_flit[p] = {$urandom, $urandom};
        end
    endtask

    // One clock: drive, sample the handshakes just before the edge, then
    // advance the model and compare just after the edge.
    task automatic step();
        logic rst_s, clr_s;
        apply();
        #1;
        rst_s = rst;
        clr_s = cnt_clr;
        for (int b = 0; b < NB; b++) begin
            f_in[b]    = in_v[b] & i_ready(b);
            f_in_d[b]  = in_d[b];
            f_out[b]   = o_valid(b) & out_r[b];
            f_out_d[b] = o_flit(b);
        end
        @(posedge clk);
        #1;
        if (rst_s) begin
            for (int b = 0; b < NB; b++) begin
                q[b].delete();
                cnt_m[b] = '0;
                in_v[b]  = 1'b0;
            end
            rdy_ok = 1'b0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (f_out[b]) begin
                    if (q[b].size() == 0) begin
                        check("spurious_pop", f_out[b], 1'b0);
                    end else begin
                        check("order", f_out_d[b], q[b].pop_front());
                        if (b == 2 && rec2) obs2.push_back(f_out_d[b]);
                        if (cnt_m[b] != 32'hFFFF_FFFF) cnt_m[b] = cnt_m[b] + 1;
                        rcvd[b]++;
                    end
                end
                if (clr_s) cnt_m[b] = '0;
                if (f_in[b]) begin
                    q[b].push_back(f_in_d[b]);
                    in_v[b] = 1'b0;
                    sent[b]++;
                end
            end
            rdy_ok = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            check("valid", o_valid(b), q[b].size() > 0);
            if (q[b].size() > 0) check("flit", o_flit(b), q[b][0]);
            check("ready", i_ready(b), rdy_ok && (q[b].size() < 2));
        end
`ifdef NOC_POS_MUX_STATS_EN
        for (int p = 0; p < NP; p++) begin
            check("ing_cnt", ing_cnt[p], cnt_m[p]);
            check("egr_cnt", egr_cnt[p], cnt_m[p+4]);
        end
`endif
        check("edge_rtr_out_valid", bus_e.rtr_out_valid[0], 1'b0);
        check("edge_lnk_out_valid", bus_e.lnk_out_valid[0], 1'b0);
        check("edge_lnk_in_ready",  bus_e.lnk_in_ready[0],  1'b0);
        check("edge_rtr_in_ready",  bus_e.rtr_in_ready[0],  1'b1);
        check("edge_rtr_out_flit",  bus_e.rtr_out_flit[0],  64'h0);
        check("edge_lnk_out_flit",  bus_e.lnk_out_flit[0],  64'h0);
    endtask

    initial begin
        bit done;
        for (int b = 0; b < NB; b++) begin
            in_v[b] = 1'b0; in_d[b] = '0; out_r[b] = 1'b1;
            cnt_m[b] = '0; sent[b] = 0; rcvd[b] = 0;
        end
        rdy_ok = 1'b0;
        rec2   = 1'b0;

        // Reset: everything idle, readies low
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rdy_after_rst_lnk", bus.lnk_in_ready, 4'hF);
        check("rdy_after_rst_rtr", bus.rtr_in_ready, 4'hF);

        // Single-cycle latency on east ingress
        in_v[0] = 1'b1; in_d[0] = 64'hA5;
        step();
        check("lat_valid", bus.rtr_out_valid[0], 1'b1);
        check("lat_flit",  bus.rtr_out_flit[0],  64'hA5);
        step();

        // South ingress stalled: two accepted, third back-pressured
        out_r[2] = 1'b0; rec2 = 1'b1; obs2.delete();
        in_v[2] = 1'b1; in_d[2] = 64'h1; step();
        in_v[2] = 1'b1; in_d[2] = 64'h2; step();
        check("south_full_ready", bus.lnk_in_ready[2], 1'b0);
        in_v[2] = 1'b1; in_d[2] = 64'h3; step();
        check("south_stall_valid", bus.rtr_out_valid[2], 1'b1);
        check("south_stall_flit",  bus.rtr_out_flit[2],  64'h1);
        out_r[2] = 1'b1;
        repeat (6) step();
        rec2 = 1'b0;
        check("south_count", obs2.size(), 3);
        for (int i = 0; i < 3; i++)
            check("south_order", (obs2.size() > i) ? obs2[i] : 64'hFFFF, 64'(i + 1));

        // Reset while a buffer is full
        out_r[2] = 1'b0;
        in_v[2] = 1'b1; in_d[2] = 64'hDEAD; step();
        in_v[2] = 1'b1; in_d[2] = 64'hBEEF; step();
        check("full_before_rst", bus.lnk_in_ready[2], 1'b0);
        rst = 1'b1;
        step();
        check("rst_valid", bus.rtr_out_valid[2], 1'b0);
        rst = 1'b0;
        out_r[2] = 1'b1;
        repeat (4) step();
        check("no_stale", bus.rtr_out_valid[2], 1'b0);

        // North egress: five flits, then a clear that collides with a pop
        for (int i = 0; i < 5; i++) begin
            in_v[7] = 1'b1; in_d[7] = 64'(100 + i);
            step();
        end
        repeat (2) step();
`ifdef NOC_POS_MUX_STATS_EN
        check("egr_cnt_five", egr_cnt[3], 32'd5);
`endif
        in_v[7] = 1'b1; in_d[7] = 64'h77;
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
`ifdef NOC_POS_MUX_STATS_EN
        check("egr_cnt_clr", egr_cnt[3], 32'd0);
`endif
        step();

        // Random traffic on all eight buffers
        for (int b = 0; b < NB; b++) begin
            sent[b] = 0; rcvd[b] = 0;
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
            for (int b = 0; b < NB; b++) begin
                if (!in_v[b] && sent[b] < NFLITS && ($urandom_range(3) != 0)) begin
                    in_v[b] = 1'b1;
                    in_d[b] = {$urandom, $urandom};
                end
                out_r[b] = ($urandom_range(3) != 0);
            end
            step();
            done = 1'b1;
            for (int b = 0; b < NB; b++)
                if (sent[b] < NFLITS || q[b].size() != 0 || in_v[b]) done = 1'b0;
        end
        check("rand_done", done, 1'b1);
        for (int b = 0; b < NB; b++) check("rand_rcvd", rcvd[b], NFLITS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
